// File: rtl/qed_commit_checker.sv
// qed_commit_checker: pairs original-stream register writebacks with their QED duplicates and latches the first divergence
// Ports: clk/rst (async active-high); commit_valid/commit_is_dup/commit_rd/commit_data retire one writeback per cycle;
// qed_clear synchronously empties the FIFO and clears the error; qed_ready/qed_error/err_code/err_rd report status;
// pending_cnt counts queued originals; exp_data/act_data hold mismatch values when QED_MISMATCH_CAPTURE_EN is defined, else 0.
module qed_commit_checker #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic                     commit_is_dup,
    input  logic [4:0]               commit_rd,
    input  logic [31:0]              commit_data,
    input  logic                     qed_clear,
    output logic                     qed_ready,
    output logic                     qed_error,
    output logic [1:0]               err_code,
    output logic [4:0]               err_rd,
    output logic [$clog2(DEPTH):0]   pending_cnt,
    output logic [31:0]              exp_data,
    output logic [31:0]              act_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] P1 = 1;
    localparam logic [AW:0] C1 = 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] wptr, rptr;
    logic [35:0] mem [DEPTH];
    logic [35:0] head;
    logic act, full, empty, orig_ok, dup_ok, push, pop, err;
    logic [1:0] code;
    always_comb begin
        head = mem[rptr];
        act = state == RUN && commit_valid && commit_rd != 5'd0 && !qed_clear;
        full = pending_cnt == FULL;
        empty = pending_cnt == '0;
        // originals live in x1..x15, duplicates in x17..x31 (same low nibble)
        orig_ok = !commit_rd[4];
        dup_ok = commit_rd[4] && commit_rd[3:0] != 4'd0;
        push = act && !commit_is_dup && orig_ok && !full;
        pop = act && commit_is_dup && dup_ok && !empty;
        code = !(commit_is_dup ? dup_ok : orig_ok) ? 2'b11 :
               commit_is_dup ? (empty ? 2'b10 : head != {commit_rd[3:0], commit_data} ? 2'b01 : 2'b00) :
               full ? 2'b11 : 2'b00;
        err = act && code != 2'b00;
        state_nxt = err ? HALT : state;
        qed_ready = empty && !qed_error;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else state <= qed_clear ? RUN : state_nxt;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {commit_rd[3:0], commit_data};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            pending_cnt <= '0;
            qed_error <= 1'b0;
            err_code <= 2'b00;
            err_rd <= 5'd0;
        end else if (qed_clear) begin
            wptr <= '0;
            rptr <= '0;
            pending_cnt <= '0;
            qed_error <= 1'b0;
            err_code <= 2'b00;
            err_rd <= 5'd0;
        end else begin
            if (push) wptr <= wptr + P1;
            if (pop) rptr <= rptr + P1;
            pending_cnt <= push ? pending_cnt + C1 : pop ? pending_cnt - C1 : pending_cnt;
            if (err) begin
                qed_error <= 1'b1;
                err_code <= code;
                err_rd <= commit_rd;
            end
        end
    end
`ifdef QED_MISMATCH_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_data <= '0;
            act_data <= '0;
        end else if (qed_clear) begin
            exp_data <= '0;
            act_data <= '0;
        end else if (err && code == 2'b01) begin
            exp_data <= head[31:0];
            act_data <= commit_data;
        end
    end
`else
    assign exp_data = '0;
    assign act_data = '0;
`endif
endmodule

// File: tb/tb_qed_commit_checker.sv
// tb_qed_commit_checker: directed scoreboard bench for qed_commit_checker (DEPTH=8)
module tb_qed_commit_checker;
    logic clk = 0, rst = 1, commit_valid = 0, commit_is_dup = 0, qed_clear = 0;
    logic [4:0] commit_rd = 0;
    logic [31:0] commit_data = 0;
    logic qed_ready, qed_error;
    logic [1:0] err_code;
    logic [4:0] err_rd;
    logic [3:0] pending_cnt;
    logic [31:0] exp_data, act_data;
`ifdef QED_MISMATCH_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif
    typedef struct {string tag; logic err; logic [1:0] code; logic [4:0] rd; logic [3:0] cnt; logic [31:0] x; logic [31:0] a;} exp_t;
    typedef struct {logic [4:0] rd; logic [31:0] d;} ent_t;
    exp_t sbq[$];
    ent_t model[$];
    int n_cmp = 0, n_bad = 0;

    qed_commit_checker #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_is_dup(commit_is_dup),
        .commit_rd(commit_rd), .commit_data(commit_data), .qed_clear(qed_clear),
        .qed_ready(qed_ready), .qed_error(qed_error), .err_code(err_code), .err_rd(err_rd),
        .pending_cnt(pending_cnt), .exp_data(exp_data), .act_data(act_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cap(input logic [31:0] v);
        return v & {32{CAP}};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic e_err, input logic [1:0] e_code, input logic [4:0] e_rd,
                                input logic [3:0] e_cnt, input logic [31:0] e_x, input logic [31:0] e_a);
        exp_t e;
        e.tag = tag; e.err = e_err; e.code = e_code; e.rd = e_rd; e.cnt = e_cnt; e.x = e_x; e.a = e_a;
        sbq.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sbq.pop_front();
        cmp({e.tag, ".qed_error"}, qed_error, e.err);
        cmp({e.tag, ".err_code"}, err_code, e.code);
        cmp({e.tag, ".err_rd"}, err_rd, e.rd);
        cmp({e.tag, ".pending_cnt"}, pending_cnt, e.cnt);
        cmp({e.tag, ".qed_ready"}, qed_ready, e.cnt == 0 && !e.err);
        cmp({e.tag, ".exp_data"}, exp_data, e.x);
        cmp({e.tag, ".act_data"}, act_data, e.a);
    endtask

    task automatic drive(input bit clr, input bit v, input bit dup, input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        qed_clear = clr; commit_valid = v; commit_is_dup = dup; commit_rd = rd; commit_data = d;
        @(posedge clk);
        #1;
        qed_clear = 0; commit_valid = 0;
    endtask

    task automatic step(input string tag, input bit clr, input bit v, input bit dup, input logic [4:0] rd, input logic [31:0] d,
                        input logic e_err, input logic [1:0] e_code, input logic [4:0] e_rd, input logic [3:0] e_cnt,
                        input logic [31:0] e_x = 0, input logic [31:0] e_a = 0);
        expect_state(tag, e_err, e_code, e_rd, e_cnt, e_x, e_a);
        drive(clr, v, dup, rd, d);
        check();
    endtask

    initial begin
        ent_t e;
        logic [4:0] r;
        logic [31:0] d;
        expect_state("reset", 0, 2'b00, 0, 0, 0, 0);
        #12;
        check();
        @(negedge clk);
        rst = 0;
        step("r36_orig", 0, 1, 0, 3, 32'h1234, 0, 2'b00, 0, 1);
        step("r36_dup", 0, 1, 1, 19, 32'h1234, 0, 2'b00, 0, 0);
        step("r37_orig", 0, 1, 0, 5, 32'hA, 0, 2'b00, 0, 1);
        step("r37_dup", 0, 1, 1, 21, 32'hB, 1, 2'b01, 21, 0, cap(32'hA), cap(32'hB));
        step("halt_hold", 0, 1, 0, 7, 32'h77, 1, 2'b01, 21, 0, cap(32'hA), cap(32'hB));
        step("clear1", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step("r38_dup", 0, 1, 1, 17, 32'h5, 1, 2'b10, 17, 0);
        step("r38_orig", 0, 1, 0, 1, 32'h6, 1, 2'b10, 17, 0);
        step("clear2", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 1; i <= 8; i++)
            step($sformatf("r39_o%0d", i), 0, 1, 0, 5'(i), 32'(i * 16), 0, 2'b00, 0, 4'(i));
        step("r39_o9", 0, 1, 0, 9, 32'h90, 1, 2'b11, 9, 8);
        step("clear3", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step("r39_stale_dup", 0, 1, 1, 17, 32'h10, 1, 2'b10, 17, 0);
        step("clear4", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step("r40_o2", 0, 1, 0, 2, 32'h22, 0, 2'b00, 0, 1);
        step("r40_o0", 0, 1, 0, 0, 32'h99, 0, 2'b00, 0, 1);
        step("r40_d0", 0, 1, 1, 0, 32'h99, 0, 2'b00, 0, 1);
        step("r40_d16", 0, 1, 1, 16, 32'h22, 1, 2'b11, 16, 1);
        step("clear5", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step("r40_o18", 0, 1, 0, 18, 32'h18, 1, 2'b11, 18, 0);
        step("clear6", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step("rdmis_orig", 0, 1, 0, 4, 32'h5, 0, 2'b00, 0, 1);
        step("rdmis_dup", 0, 1, 1, 22, 32'h5, 1, 2'b01, 22, 0, cap(32'h5), cap(32'h5));
        step("clear7", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        step("clr_commit", 1, 1, 0, 3, 32'h33, 0, 2'b00, 0, 0);
        step("clr_commit_dup", 0, 1, 1, 19, 32'h33, 1, 2'b10, 19, 0);
        step("clear8", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        for (int k = 0; k < 20; k++) begin
            if (k >= 2) begin
                e = model.pop_front();
                step($sformatf("wrap_d%0d", k - 2), 0, 1, 1, e.rd + 5'd16, e.d, 0, 2'b00, 0, 4'(model.size()));
            end
            r = 5'((k % 15) + 1);
            d = $urandom;
            e.rd = r; e.d = d;
            model.push_back(e);
            step($sformatf("wrap_o%0d", k), 0, 1, 0, r, d, 0, 2'b00, 0, 4'(model.size()));
        end
        for (int k = 18; k < 20; k++) begin
            e = model.pop_front();
            step($sformatf("wrap_d%0d", k), 0, 1, 1, e.rd + 5'd16, e.d, 0, 2'b00, 0, 4'(model.size()));
        end
        for (int i = 1; i <= 3; i++)
            step($sformatf("prerst_o%0d", i), 0, 1, 0, 5'(i + 10), 32'(i), 0, 2'b00, 0, 4'(i));
        @(negedge clk);
        rst = 1;
        expect_state("mid_rst", 0, 2'b00, 0, 0, 0, 0);
        #1;
        check();
        @(negedge clk);
        rst = 0;
        step("post_rst_dup", 0, 1, 1, 27, 32'h1, 1, 2'b10, 27, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/qed_commit_checker.md
QED_COMMIT_CHECKER -- requirements
Module: qed_commit_checker

Interface
REQ-001: Parameter DEPTH, default 8, SHALL set the number of pending-original entries, power of two, range 2..32.
REQ-002: The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003: clk  input  1  rising-edge clock for all state.
REQ-004: rst  input  1  asynchronous active-high reset.
REQ-005: commit_valid  input  1  one register writeback retires this cycle.
REQ-006: commit_is_dup  input  1  retiring instruction belongs to the duplicate (QED) stream; 0 means original stream.
REQ-007: commit_rd  input  5  destination register of the retiring instruction.
REQ-008: commit_data  input  32  value written to commit_rd.
REQ-009: qed_clear  input  1  synchronous clear of FIFO, error state and counters.
REQ-010: qed_ready  output  1  high when no original write is awaiting its duplicate (FIFO empty) and no error is latched.
REQ-011: qed_error  output  1  sticky error flag.
REQ-012: err_code  output  2  00 none, 01 data/register mismatch, 10 underflow (duplicate with no pending original), 11 overflow or illegal register half.
REQ-013: err_rd  output  5  commit_rd of the commit that raised the error.
REQ-014: pending_cnt  output  $clog2(DEPTH)+1  number of queued original writes.
REQ-015: exp_data, act_data  output  32 each  expected and actual values of a mismatch (REQ-034).

Function
REQ-016: Commits with commit_rd == 0 SHALL be ignored in both streams.
REQ-017: An original commit (commit_is_dup=0) SHALL have rd in 1..15 and a duplicate commit SHALL have rd in 17..31; any other nonzero rd SHALL raise err_code 11.
REQ-018: A legal original commit SHALL push {rd[3:0], data} into an in-order FIFO of DEPTH entries.
REQ-019: A legal duplicate commit SHALL pop the FIFO head and compare head rd[3:0] with commit_rd[3:0] and head data with commit_data.
REQ-020: Any compare inequality SHALL raise err_code 01; equality SHALL raise nothing.
REQ-021: A duplicate commit with the FIFO empty SHALL raise err_code 10 and SHALL not change pointers.
REQ-022: An original commit with the FIFO full SHALL raise err_code 11, and the entry SHALL be dropped.
REQ-023: Read and write pointers SHALL wrap modulo DEPTH; pending_cnt SHALL distinguish full (DEPTH) from empty (0).
REQ-024: The state machine SHALL have two states: RUN and HALT.
REQ-025: RUN SHALL move to HALT on any error, registering err_code, err_rd, qed_error=1 at the next rising edge (1-cycle latency).
REQ-026: HALT SHALL ignore all commits, holding FIFO, pointers and error outputs.
REQ-027: HALT SHALL leave only via rst or qed_clear.
REQ-028: The first error SHALL win, and later commits SHALL not overwrite err_code/err_rd.
REQ-029: When qed_clear is high, it SHALL take priority over a same-cycle commit: FIFO emptied, pending_cnt=0, error outputs zeroed, state RUN; that commit is discarded.
REQ-030: qed_ready SHALL be combinational from registered state only: (pending_cnt==0) and not qed_error.

Reset
REQ-031: Asserting rst SHALL immediately force state RUN, pointers 0, pending_cnt 0, qed_error 0, err_code 00, err_rd 0, exp_data 0, act_data 0; qed_ready then reads 1.
REQ-032: rst asserted mid-sequence SHALL discard all pending entries, with no error raised for them after release.
REQ-033: FIFO data storage SHALL not require reset.

Configuration
REQ-034: Macro QED_MISMATCH_CAPTURE_EN defined: on an err_code 01 event, exp_data SHALL latch head data and act_data SHALL latch commit_data, held until rst/qed_clear.
REQ-035: Macro QED_MISMATCH_CAPTURE_EN undefined: exp_data and act_data SHALL be constant 0 and no capture registers SHALL exist; all other behaviour is unchanged.

Verification
REQ-036: Original rd=3 data=0x1234, then dup rd=19 data=0x1234 -> pending_cnt 1 then 0, qed_ready 1, qed_error 0.
REQ-037: Original rd=5 data=0xA, then dup rd=21 data=0xB -> next cycle qed_error 1, err_code 01, err_rd 21; with macro, exp_data 0xA and act_data 0xB.
REQ-038: Dup rd=17 after reset -> err_code 10, err_rd 17, HALT; a following original rd=1 leaves pending_cnt 0.
REQ-039: DEPTH=8, nine originals rd=1..9 -> ninth raises err_code 11, err_rd 9, pending_cnt 8; eight matching dups after qed_clear are not checked against stale data (pending_cnt 0 after clear, dup raises 10).
REQ-040: Originals rd=2, rd=0, dup rd=16 -> rd=0 commits ignored, dup rd=16 raises err_code 11; original rd=18 on a fresh run raises 11.
REQ-041: Pointer wrap: 20 matched original/dup pairs interleaved two-deep -> no error, pending_cnt ends 0; rst asserted with pending_cnt 3 -> all outputs at reset values same cycle.
